// File: rtl/minterm_sweep_if.sv
// minterm_sweep_if
// Groups the control/status handshake and the function-under-sweep
// connections of minterm_sweep_ctrl.
//   start, expected : sweep request and expected truth table (master -> slave)
//   f_in            : F output of the function being swept   (master -> slave)
//   abcd            : {A,B,C,D} drive, A = bit 3              (slave -> master)
//   busy, done, pass, truth, fail_cnt, fail_idx : sweep status (slave -> master)
interface minterm_sweep_if;
    logic        start;
    logic [15:0] expected;
    logic        f_in;
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] truth;
    logic [4:0]  fail_cnt;
    logic [3:0]  fail_idx;

    modport master (
        output start, expected, f_in,
        input  abcd, busy, done, pass, truth, fail_cnt, fail_idx
    );

    modport slave (
        input  start, expected, f_in,
        output abcd, busy, done, pass, truth, fail_cnt, fail_idx
    );
endinterface

// File: rtl/minterm_sweep_ctrl.sv
// minterm_sweep_ctrl
// Walks a 4-input combinational function through all 16 input codes,
// captures its truth table and compares it with a mask latched at start.
//
// Parameters:
//   SETTLE : extra idle clocks each vector is held before F is sampled (0..15)
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : minterm_sweep_if.slave (start/expected/f_in in, abcd/status out)
// Build option:
//   MINTERM_SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatching
//   vector ends the sweep; otherwise all 16 vectors are always swept.
module minterm_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    minterm_sweep_if.slave bus
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [3:0]  idx_r, idx_nx_s;
    logic [3:0]  cnt_r, cnt_nx_s;
    logic [15:0] exp_r, exp_nx_s;
    logic [15:0] truth_r, truth_nx_s;
    logic [4:0]  fail_cnt_r, fail_cnt_nx_s;
    logic [3:0]  fail_idx_r, fail_idx_nx_s;
    logic        pass_r, pass_nx_s;
    logic        done_r, done_nx_s;
    logic        busy_r, busy_nx_s;
    logic        sample_s;
    logic        miss_s;
    logic        last_s;

    // State and datapath registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 4'd0;
            cnt_r      <= 4'd0;
            exp_r      <= 16'd0;
            truth_r    <= 16'd0;
            fail_cnt_r <= 5'd0;
            fail_idx_r <= 4'd0;
            pass_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            idx_r      <= idx_nx_s;
            cnt_r      <= cnt_nx_s;
            exp_r      <= exp_nx_s;
            truth_r    <= truth_nx_s;
            fail_cnt_r <= fail_cnt_nx_s;
            fail_idx_r <= fail_idx_nx_s;
            pass_r     <= pass_nx_s;
            done_r     <= done_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    // Next-state and next-datapath logic for the sweep sequencer.
    always_comb begin
        state_nx_s    = state_r;
        idx_nx_s      = idx_r;
        cnt_nx_s      = cnt_r;
        exp_nx_s      = exp_r;
        truth_nx_s    = truth_r;
        fail_cnt_nx_s = fail_cnt_r;
        fail_idx_nx_s = fail_idx_r;
        pass_nx_s     = pass_r;
        sample_s      = (state_r == ST_DRIVE) && (cnt_r == SETTLE_C);
        miss_s        = sample_s && (bus.f_in != exp_r[idx_r]);
`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
        last_s        = (idx_r == 4'd15) || miss_s;
`else
        last_s        = (idx_r == 4'd15);
`endif

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s    = ST_DRIVE;
                    exp_nx_s      = bus.expected;
                    truth_nx_s    = 16'd0;
                    fail_cnt_nx_s = 5'd0;
                    fail_idx_nx_s = 4'd0;
                    pass_nx_s     = 1'b0;
                    idx_nx_s      = 4'd0;
                    cnt_nx_s      = 4'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (sample_s) begin
                    truth_nx_s[idx_r] = bus.f_in;
                    if (miss_s) begin
                        fail_cnt_nx_s = fail_cnt_r + 5'd1;
                        // fail_idx only latches on the first mismatch of the sweep
                        if (fail_cnt_r == 5'd0) begin
                            fail_idx_nx_s = idx_r;
                        end else begin
                            fail_idx_nx_s = fail_idx_r;
                        end
                    end else begin
                        fail_cnt_nx_s = fail_cnt_r;
                    end
                    if (last_s) begin
                        // idx stays on the final vector so abcd holds it afterwards
                        state_nx_s = ST_DONE;
                        pass_nx_s  = (fail_cnt_nx_s == 5'd0);
                    end else begin
                        idx_nx_s = idx_r + 4'd1;
                        cnt_nx_s = 4'd0;
                    end
                end else begin
                    cnt_nx_s = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        done_nx_s = (state_nx_s == ST_DONE);
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    assign bus.abcd     = idx_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.truth    = truth_r;
    assign bus.fail_cnt = fail_cnt_r;
    assign bus.fail_idx = fail_idx_r;

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// tb_minterm_sweep_ctrl
// Drives two sweepers (SETTLE=1 and SETTLE=0) with the same start/expected
// stimulus, each looking at its own copy of the function under sweep.
module tb_minterm_sweep_ctrl;

`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        int          lat;
        logic [15:0] truth;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  idx;
        logic [3:0]  last;
    } res_t;

    typedef struct {
        logic [15:0] fn;
        logic [15:0] ex;
        bit          noise;
        res_t        r1;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] func_mask;
    int          checks;
    int          errors;
    int          cur_test;

    minterm_sweep_if if1 ();
    minterm_sweep_if if0 ();

    assign if1.f_in = func_mask[if1.abcd];
    assign if0.f_in = func_mask[if0.abcd];

    minterm_sweep_ctrl #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    minterm_sweep_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog test=%0d act=timeout req=finish", cur_test);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s test=%0d act=%0h req=%0h", name, cur_test, act, req);
        end
    endtask

    // Reference result from the rules: mismatch mask, optional stop at first miss.
    function automatic res_t model(input logic [15:0] fn, input logic [15:0] ex, input int s);
        res_t        r;
        logic [15:0] diff;
        logic [16:0] m;
        int          n;
        diff = fn ^ ex;
        n = 16;
        if (STOP) begin
            for (int k = 15; k >= 0; k--) if (diff[k]) n = k + 1;
        end
        m       = (17'd1 << n) - 17'd1;
        diff    = diff & m[15:0];
        r.lat   = n * (s + 1);
        r.last  = 4'(n - 1);
        r.truth = fn & m[15:0];
        r.cnt   = 5'($countones(diff));
        r.pass  = (diff == 16'd0);
        r.idx   = 4'd0;
        for (int k = 15; k >= 0; k--) if (diff[k]) r.idx = 4'(k);
        return r;
    endfunction

    task automatic set_start(input logic v, input logic [15:0] e);
        if1.start = v; if0.start = v;
        if1.expected = e; if0.expected = e;
    endtask

    task automatic run_sweep(input logic [15:0] fn, input logic [15:0] ex, input bit noise,
                             input res_t e1, input res_t e0);
        int   lat1, lat0, d1, d0;
        res_t g1, g0;
        func_mask = fn;
        lat1 = -1; lat0 = -1; d1 = 0; d0 = 0;
        g1 = '{0, 16'd0, 1'b0, 5'd0, 4'd0, 4'd0};
        g0 = g1;
        @(negedge clk);
        set_start(1'b1, ex);
        @(posedge clk); #1;
        set_start(1'b0, ex);
        chk("busy1_after_start", 32'(if1.busy), 32'd1);
        chk("busy0_after_start", 32'(if0.busy), 32'd1);
        chk("abcd1_after_start", 32'(if1.abcd), 32'd0);
        for (int c = 1; c <= 400 && (lat1 < 0 || lat0 < 0); c++) begin
            @(posedge clk); #1;
            if (lat1 < 0 && !if1.done) chk("abcd1_step", 32'(if1.abcd), 32'(c / 2));
            if (lat0 < 0 && !if0.done) chk("abcd0_step", 32'(if0.abcd), 32'(c));
            if (if1.done) begin
                d1++;
                if (lat1 < 0) begin
                    lat1 = c;
                    g1 = '{c, if1.truth, if1.pass, if1.fail_cnt, if1.fail_idx, if1.abcd};
                    chk("busy1_in_done", 32'(if1.busy), 32'd1);
                end
            end
            if (if0.done) begin
                d0++;
                if (lat0 < 0) begin
                    lat0 = c;
                    g0 = '{c, if0.truth, if0.pass, if0.fail_cnt, if0.fail_idx, if0.abcd};
                end
            end
            // hammer start (with junk masks) while the short sweeper is busy, including its done cycle
            if (noise && if0.busy) set_start(1'b1, 16'($urandom));
            else set_start(1'b0, ex);
        end
        chk("lat1", 32'(lat1), 32'(e1.lat));
        chk("truth1", 32'(g1.truth), 32'(e1.truth));
        chk("pass1", 32'(g1.pass), 32'(e1.pass));
        chk("fail_cnt1", 32'(g1.cnt), 32'(e1.cnt));
        chk("fail_idx1", 32'(g1.idx), 32'(e1.idx));
        chk("abcd1_last", 32'(g1.last), 32'(e1.last));
        chk("lat0", 32'(lat0), 32'(e0.lat));
        chk("truth0", 32'(g0.truth), 32'(e0.truth));
        chk("pass0", 32'(g0.pass), 32'(e0.pass));
        chk("fail_cnt0", 32'(g0.cnt), 32'(e0.cnt));
        chk("fail_idx0", 32'(g0.idx), 32'(e0.idx));
        @(posedge clk); #1;
        chk("done1_pulses", 32'(d1 + 32'(if1.done)), 32'd1);
        chk("done0_pulses", 32'(d0 + 32'(if0.done)), 32'd1);
        chk("busy1_after_done", 32'(if1.busy), 32'd0);
        chk("busy0_after_done", 32'(if0.busy), 32'd0);
        chk("pass1_held", 32'(if1.pass), 32'(e1.pass));
        chk("abcd1_held", 32'(if1.abcd), 32'(e1.last));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_abcd1"}, 32'(if1.abcd), 32'd0);
        chk({tag, "_busy1"}, 32'(if1.busy), 32'd0);
        chk({tag, "_done1"}, 32'(if1.done), 32'd0);
        chk({tag, "_pass1"}, 32'(if1.pass), 32'd0);
        chk({tag, "_truth1"}, 32'(if1.truth), 32'd0);
        chk({tag, "_cnt1"}, 32'(if1.fail_cnt), 32'd0);
        chk({tag, "_idx1"}, 32'(if1.fail_idx), 32'd0);
        chk({tag, "_truth0"}, 32'(if0.truth), 32'd0);
        chk({tag, "_pass0"}, 32'(if0.pass), 32'd0);
        chk({tag, "_abcd0"}, 32'(if0.abcd), 32'd0);
    endtask

    vec_t tbl [4];

    initial begin
        logic [15:0] fn, ex;
        checks = 0; errors = 0; cur_test = 0;
        func_mask = 16'hEF77;
        set_start(1'b0, 16'd0);

        tbl[0] = '{16'hEF77, 16'hEF77, 1'b0, '{32, 16'hEF77, 1'b1, 5'd0, 4'd0, 4'd15}};
`ifdef MINTERM_SWEEP_STOP_ON_FAIL_EN
        tbl[1] = '{16'hEF77, 16'hEF7F, 1'b0, '{8, 16'h0007, 1'b0, 5'd1, 4'd3, 4'd3}};
        tbl[2] = '{16'hEF77, 16'h0000, 1'b0, '{2, 16'h0001, 1'b0, 5'd1, 4'd0, 4'd0}};
`else
        tbl[1] = '{16'hEF77, 16'hEF7F, 1'b0, '{32, 16'hEF77, 1'b0, 5'd1, 4'd3, 4'd15}};
        tbl[2] = '{16'hEF77, 16'h0000, 1'b0, '{32, 16'hEF77, 1'b0, 5'd13, 4'd0, 4'd15}};
`endif
        tbl[3] = '{16'hEF77, 16'hEF77, 1'b1, '{32, 16'hEF77, 1'b1, 5'd0, 4'd0, 4'd15}};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cur_test = i + 1;
            run_sweep(tbl[i].fn, tbl[i].ex, tbl[i].noise, tbl[i].r1, model(tbl[i].fn, tbl[i].ex, 0));
        end

        // Abort at vector 7 of the SETTLE=1 sweeper, then a clean full sweep.
        cur_test = 10;
        func_mask = 16'hEF77;
        @(negedge clk);
        set_start(1'b1, 16'hEF77);
        @(posedge clk); #1;
        set_start(1'b0, 16'hEF77);
        for (int c = 0; c < 100 && if1.abcd != 4'd7; c++) begin
            @(posedge clk); #1;
        end
        chk("reached_vec7", 32'(if1.abcd), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (if1.done || if1.busy) chk("no_done_after_abort", 32'(if1.done) | 32'(if1.busy), 32'd0);
        end
        cur_test = 11;
        run_sweep(16'hEF77, 16'hEF77, 1'b0, model(16'hEF77, 16'hEF77, 1), model(16'hEF77, 16'hEF77, 0));

        // Random functions and masks against the reference model.
        for (int i = 0; i < 20; i++) begin
            cur_test = 100 + i;
            fn = 16'($urandom);
            if ($urandom_range(0, 2) == 0) ex = fn;
            else ex = fn ^ (16'($urandom) & 16'($urandom));
            run_sweep(fn, ex, 1'($urandom_range(0, 1)), model(fn, ex, 1), model(fn, ex, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
